// File: rtl/jtag_tap_responder_if.sv
// Pin-side and client-side signals of the JTAG TAP responder.
// slave is the TAP's view; master is the host/client view.
interface jtag_tap_responder_if #(
  parameter int IR_W = 6,
  parameter int DR_W = 41
);
  logic            tck;
  logic            tms;
  logic            tdi;
  logic            tdo;
  logic            tdo_en;
  logic [3:0]      tap_state;
  logic [IR_W-1:0] ir_out;
  logic [DR_W-1:0] user_cap_data;
  logic            user_cap;
  logic            user_upd;
  logic [DR_W-1:0] user_upd_data;

  modport master (
    output tck, tms, tdi, user_cap_data,
    input  tdo, tdo_en, tap_state, ir_out, user_cap, user_upd, user_upd_data
  );

  modport slave (
    input  tck, tms, tdi, user_cap_data,
    output tdo, tdo_en, tap_state, ir_out, user_cap, user_upd, user_upd_data
  );
endinterface

// File: rtl/jtag_tap_responder.sv
// IEEE 1149.1 TAP responder, oversampled in the clk domain (IDCODE, BYPASS, USER DR).
// Optional JTAG_TAP_TRST_EN adds a synchronized active-low trst_n input.
module jtag_tap_responder #(
  parameter int              IR_W       = 6,
  parameter int              DR_W       = 41,
  parameter logic [31:0]     IDCODE_VAL = 32'h1BEEF001,
  parameter logic [IR_W-1:0] IR_IDCODE  = 6'h01,
  parameter logic [IR_W-1:0] IR_USER    = 6'h11
) (
  input  logic clk,
  input  logic rst,
`ifdef JTAG_TAP_TRST_EN
  input  logic trst_n,
`endif
  jtag_tap_responder_if.slave bus
);

  localparam logic [3:0] TLR   = 4'hF;
  localparam logic [3:0] RTI   = 4'hC;
  localparam logic [3:0] SELDR = 4'h7;
  localparam logic [3:0] CAPDR = 4'h6;
  localparam logic [3:0] SHDR  = 4'h2;
  localparam logic [3:0] EX1DR = 4'h1;
  localparam logic [3:0] PSDR  = 4'h3;
  localparam logic [3:0] EX2DR = 4'h0;
  localparam logic [3:0] UPDR  = 4'h5;
  localparam logic [3:0] SELIR = 4'h4;
  localparam logic [3:0] CAPIR = 4'hE;
  localparam logic [3:0] SHIR  = 4'hA;
  localparam logic [3:0] EX1IR = 4'h9;
  localparam logic [3:0] PSIR  = 4'hB;
  localparam logic [3:0] EX2IR = 4'h8;
  localparam logic [3:0] UPIR  = 4'hD;

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
    case (s)
      TLR:     tap_next = m ? TLR   : RTI;
      RTI:     tap_next = m ? SELDR : RTI;
      SELDR:   tap_next = m ? SELIR : CAPDR;
      CAPDR:   tap_next = m ? EX1DR : SHDR;
      SHDR:    tap_next = m ? EX1DR : SHDR;
      EX1DR:   tap_next = m ? UPDR  : PSDR;
      PSDR:    tap_next = m ? EX2DR : PSDR;
      EX2DR:   tap_next = m ? UPDR  : SHDR;
      UPDR:    tap_next = m ? SELDR : RTI;
      SELIR:   tap_next = m ? TLR   : CAPIR;
      CAPIR:   tap_next = m ? EX1IR : SHIR;
      SHIR:    tap_next = m ? EX1IR : SHIR;
      EX1IR:   tap_next = m ? UPIR  : PSIR;
      PSIR:    tap_next = m ? EX2IR : PSIR;
      EX2IR:   tap_next = m ? UPIR  : SHIR;
      UPIR:    tap_next = m ? SELDR : RTI;
      default: tap_next = TLR;
    endcase
  endfunction

  // Stage p0/p1: pin synchronizers; p2 holds the previous tck for edge detection
  logic tck_p0, tck_p1, tck_p2;
  logic tms_p0, tms_p1;
  logic tdi_p0, tdi_p1;

  always_ff @(posedge clk) begin
    tck_p0 <= bus.tck;
    tck_p1 <= tck_p0;
    tck_p2 <= tck_p1;
    tms_p0 <= bus.tms;
    tms_p1 <= tms_p0;
    tdi_p0 <= bus.tdi;
    tdi_p1 <= tdi_p0;
  end

  logic rise, fall, trst_act;
  assign rise = tck_p1 & ~tck_p2;
  assign fall = ~tck_p1 & tck_p2;

`ifdef JTAG_TAP_TRST_EN
  logic trst_p0, trst_p1;
  always_ff @(posedge clk) begin
    trst_p0 <= trst_n;
    trst_p1 <= trst_p0;
  end
  assign trst_act = ~trst_p1;
`else
  assign trst_act = 1'b0;
`endif

  logic [3:0]      state_q, state_nxt;
  logic [IR_W-1:0] ir_q, ir_sr;
  logic [DR_W-1:0] dr_sr, upd_data_q;
  logic            byp_q, tdo_q, cap_q, upd_q;
  logic            sel_user, sel_idcode, sel_byp, in_shift;

  assign state_nxt  = tap_next(state_q, tms_p1);
  assign sel_user   = (ir_q == IR_USER);
  assign sel_idcode = (ir_q == IR_IDCODE);
  assign sel_byp    = ~sel_user & ~sel_idcode;
  assign in_shift   = (state_q == SHDR) || (state_q == SHIR);

  // Stage p2 -> state: TAP control, instruction and update handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= TLR;
      ir_q       <= IR_IDCODE;
      tdo_q      <= 1'b0;
      cap_q      <= 1'b0;
      upd_q      <= 1'b0;
      upd_data_q <= '0;
    end else begin
      cap_q <= 1'b0;
      upd_q <= 1'b0;
      if (trst_act) begin
        state_q <= TLR;
        ir_q    <= IR_IDCODE;
        tdo_q   <= 1'b0;
      end else begin
        if (rise) begin
          state_q <= state_nxt;
          if (state_q == CAPDR && sel_user) cap_q <= 1'b1;
          if (state_nxt == TLR)       ir_q <= IR_IDCODE;
          else if (state_nxt == UPIR) ir_q <= ir_sr;
          if (state_nxt == UPDR && sel_user) begin
            upd_q      <= 1'b1;
            upd_data_q <= dr_sr;
          end
        end
        if (!in_shift)
          tdo_q <= 1'b0;
        else if (fall)
          tdo_q <= (state_q == SHIR) ? ir_sr[0] : (sel_byp ? byp_q : dr_sr[0]);
      end
    end
  end

  // Shift registers are reloaded on every capture, so rst leaves them alone
  always_ff @(posedge clk) begin
    if (trst_act) begin
      ir_sr <= '0;
      dr_sr <= '0;
      byp_q <= 1'b0;
    end else if (rise) begin
      case (state_q)
        CAPIR: ir_sr <= {{(IR_W-2){1'b0}}, 2'b01};
        SHIR:  ir_sr <= {tdi_p1, ir_sr[IR_W-1:1]};
        CAPDR: begin
          byp_q <= 1'b0;
          if (sel_idcode)    dr_sr <= DR_W'(IDCODE_VAL);
          else if (sel_user) dr_sr <= bus.user_cap_data;
        end
        SHDR: begin
          if (sel_byp)         byp_q <= tdi_p1;
          else if (sel_idcode) dr_sr <= {{(DR_W-32){1'b0}}, tdi_p1, dr_sr[31:1]};
          else                 dr_sr <= {tdi_p1, dr_sr[DR_W-1:1]};
        end
        default: ;
      endcase
    end
  end

  assign bus.tdo           = tdo_q;
  assign bus.tdo_en        = in_shift;
  assign bus.tap_state     = state_q;
  assign bus.ir_out        = ir_q;
  assign bus.user_cap      = cap_q;
  assign bus.user_upd      = upd_q;
  assign bus.user_upd_data = upd_data_q;

endmodule
